// File: rtl/instruction_encoder_loader.sv
// Assembles symbolic MIPS instructions into 32-bit words and streams them into
// instruction memory at consecutive word addresses during a load session.
module instruction_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              legal;
  logic [31:0]       word;
  logic              hs;
  logic [ADDR_W:0]   count_inc;

  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    unique case (in_kind)
      4'd0:  word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd1:  word = {6'b001000, in_rs, in_rt, in_imm};
      4'd2:  word = {6'b001100, in_rs, in_rt, in_imm};
      4'd3:  word = {6'b001101, in_rs, in_rt, in_imm};
      4'd4:  word = {6'b001110, in_rs, in_rt, in_imm};
      4'd5:  word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:  word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:  word = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:  word = {6'b001111, 5'b00000, in_rt, in_imm};
      4'd9:  word = {6'b000010, in_target};
      4'd10: word = {6'b000011, in_target};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign hs        = in_valid & in_ready;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // start has priority over everything, including a concurrent handshake
    if (start) begin
      state_d = LOAD;
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == LOAD) begin
      if (hs) begin
        if (legal) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = word;
          ptr_d   = ptr_q + 1'b1;
          count_d = count_inc;
          if (count_inc == (ADDR_W+1)'(DEPTH)) state_d = DONE;
        end else begin
          err_d = 1'b1;
        end
      end
      if (finish) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign im_we       = we_q;
  assign im_addr     = addr_q;
  assign im_wdata    = wdata_q;
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign count       = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench: encoding table plus session corner cases on a 64-word and a 4-word loader.
module tb_instruction_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, finish, in_valid;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, im_we, busy, done, err_illegal;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic [6:0]  count;

  logic        in_ready2, im_we2, busy2, done2, err_illegal2;
  logic [1:0]  im_addr2;
  logic [31:0] im_wdata2;
  logic [2:0]  count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_encoder_loader #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .count(count), .err_illegal(err_illegal)
  );

  instruction_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready2), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2),
    .busy(busy2), .done(done2), .count(count2), .err_illegal(err_illegal2)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_shamt = v.shamt; in_funct = v.funct; in_imm = v.imm; in_target = v.target;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // kind, rs, rt, rd, shamt, funct, imm, target, expected word; unused fields carry junk
    vecs[0]  = '{4'd1,  5'd0,  5'd8,  5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 32'h20080005};
    vecs[1]  = '{4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h00221820};
    vecs[2]  = '{4'd10, 5'd5,  5'd6,  5'd7,  5'd8,  6'h11, 16'hBEEF, 26'h0000010, 32'h0C000010};
    vecs[3]  = '{4'd8,  5'd7,  5'd1,  5'd9,  5'd9,  6'h2A, 16'h1234, 26'h1555555, 32'h3C011234};
    vecs[4]  = '{4'd7,  5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0000000, 32'h1022FFFF};
    vecs[5]  = '{4'd6,  5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0004, 26'h0000000, 32'hAFBF0004};
    vecs[6]  = '{4'd2,  5'd2,  5'd3,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0000000, 32'h304300FF};
    vecs[7]  = '{4'd3,  5'd4,  5'd5,  5'd0,  5'd0,  6'h00, 16'hABCD, 26'h0000000, 32'h3485ABCD};
    vecs[8]  = '{4'd4,  5'd6,  5'd7,  5'd0,  5'd0,  6'h00, 16'h0001, 26'h0000000, 32'h38C70001};
    vecs[9]  = '{4'd5,  5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0008, 26'h0000000, 32'h8FA80008};
    vecs[10] = '{4'd9,  5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF};

    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {28'd0, busy, done, err_illegal, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("finish_idle_ignored", {30'd0, busy, done}, 32'd0);
    $display("[TB] finish in IDLE: busy=%0d done=%0d", busy, done);

    // back-to-back encoding table
    pulse_start();
    chk("start_busy", {30'd0, busy, in_ready}, 32'd3);
    chk("start_count", 32'(count), 32'd0);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), 32'(im_we), 32'd1);
      chk($sformatf("vec%0d_addr", i), 32'(im_addr), 32'(i));
      chk($sformatf("vec%0d_word", i), im_wdata, vecs[i].word);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(i + 1));
      $display("[TB] vec%0d kind=%0d addr=%0d word=0x%08h", i, vecs[i].kind, im_addr, im_wdata);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_we", 32'(im_we), 32'd0);
    chk("hold_addr", 32'(im_addr), 32'(NV - 1));
    chk("hold_word", im_wdata, vecs[NV-1].word);

    // illegal kind sandwiched between two legal items
    pulse_start();
    chk("restart_err", 32'(err_illegal), 32'd0);
    drive(vecs[0]); in_valid = 1'b1;
    @(negedge clk);
    chk("ill_a_addr", {31'd0, im_we}, 32'd1);
    chk("ill_a_at0", 32'(im_addr), 32'd0);
    drive(vecs[1]); in_kind = 4'd12;
    @(negedge clk);
    chk("ill_no_we", 32'(im_we), 32'd0);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count), 32'd1);
    drive(vecs[2]);
    @(negedge clk);
    chk("ill_b_we", 32'(im_we), 32'd1);
    chk("ill_b_addr", 32'(im_addr), 32'd1);
    chk("ill_b_word", im_wdata, vecs[2].word);
    chk("ill_b_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_err_sticky", 32'(err_illegal), 32'd1);
    $display("[TB] illegal kind: err_illegal=%0d count=%0d", err_illegal, count);
    pulse_start();
    chk("ill_err_cleared", 32'(err_illegal), 32'd0);

    // 4-word loader fills up
    drive(vecs[0]);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("full%0d_we", i), 32'(im_we2), 32'd1);
      chk($sformatf("full%0d_addr", i), 32'(im_addr2), 32'(i));
      chk($sformatf("full%0d_count", i), 32'(count2), 32'(i + 1));
    end
    chk("full_done", {29'd0, done2, busy2, in_ready2}, 32'd4);
    chk("full_count", 32'(count2), 32'd4);
    @(negedge clk);
    chk("full_5th_no_we", 32'(im_we2), 32'd0);
    chk("full_5th_count", 32'(count2), 32'd4);
    chk("full_stay_done", 32'(done2), 32'd1);
    in_valid = 1'b0;
    $display("[TB] full: done=%0d count=%0d", done2, count2);
    pulse_start();
    chk("done_restart_count", 32'(count2), 32'd0);
    chk("done_restart_busy", 32'(busy2), 32'd1);

    // mid-session restart with a concurrent handshake, then finish with handshake
    pulse_start();
    drive(vecs[0]); in_valid = 1'b1;
    @(negedge clk);
    chk("mid_first_addr", 32'(im_addr), 32'd0);
    drive(vecs[1]); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_drop_we", 32'(im_we), 32'd0);
    chk("mid_drop_count", 32'(count), 32'd0);
    drive(vecs[2]);
    @(negedge clk);
    chk("mid_next_addr", 32'(im_addr), 32'd0);
    chk("mid_next_word", im_wdata, vecs[2].word);
    chk("mid_next_count", 32'(count), 32'd1);
    drive(vecs[3]); finish = 1'b1;
    @(negedge clk);
    finish = 1'b0; in_valid = 1'b0;
    chk("fin_we", 32'(im_we), 32'd1);
    chk("fin_addr", 32'(im_addr), 32'd1);
    chk("fin_word", im_wdata, vecs[3].word);
    chk("fin_done", {30'd0, done, in_ready}, 32'd2);
    $display("[TB] finish+handshake: addr=%0d done=%0d count=%0d", im_addr, done, count);

    // start and finish together: start wins
    pulse_start();
    start = 1'b1; finish = 1'b1;
    @(negedge clk);
    start = 1'b0; finish = 1'b0;
    chk("start_finish", {30'd0, busy, done}, 32'd2);

    // asynchronous reset during a back-to-back load
    drive(vecs[0]); in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("prerst_we", 32'(im_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(im_we), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_flags", {29'd0, busy, done, in_ready}, 32'd0);
    chk("arst_addr", 32'(im_addr), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, in_ready}, 32'd0);
    $display("[TB] async reset: im_we=%0d busy=%0d", im_we, busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
